// File: rtl/ramb4_s2_porta_arbiter_if.sv
// ---------------------------------------------------------------------------
// ramb4_s2_porta_arbiter_if
//   Requester-side bundle of the port A arbiter.
//   N_REQ must match the N_REQ of the arbiter it is connected to.
//   Signals (slice i belongs to requester i):
//     req    [N_REQ]     request, held while accesses are wanted
//     we     [N_REQ]     write flag (1=write, 0=read), qualified by req
//     addr   [N_REQ*11]  word address, slice i = [11i+10:11i]
//     wdata  [N_REQ*2]   write data,   slice i = [2i+1:2i]
//     gnt    [N_REQ]     one-hot current owner (registered)
//     ack    [N_REQ]     access issued for requester this cycle
//     rvalid [N_REQ]     read data valid, one cycle after a read ack
//     rdata  [2]         read data, meaningful only with rvalid
//     busy               arbiter not idle
//   Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface ramb4_s2_porta_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    we;
  logic [N_REQ*11-1:0] addr;
  logic [N_REQ*2-1:0]  wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    ack;
  logic [N_REQ-1:0]    rvalid;
  logic [1:0]          rdata;
  logic                busy;

  modport master (
    output req, we, addr, wdata,
    input  gnt, ack, rvalid, rdata, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, ack, rvalid, rdata, busy
  );
endinterface

// File: rtl/ramb4_s2_porta_arbiter.sv
// ---------------------------------------------------------------------------
// ramb4_s2_porta_arbiter
//   Shares port A (2 bits x 2048 words) of a dual-port block RAM between
//   N_REQ requesters. A requester owns the port for a burst of at most
//   MAX_BURST accesses, after which the port returns to IDLE for one cycle
//   and is re-arbitrated. The owner's address, data and write strobe are
//   muxed straight onto the RAM pins; read data comes back one cycle later
//   with a per-requester rvalid pulse.
//
//   Build option: define RR_ARB_EN for round-robin arbitration. Without it
//   the lowest requesting index always wins (fixed priority).
//
//   Ports:
//     CLKA      clock, also drives the RAM port A clock
//     RSTB      synchronous active-high reset (also resets RAM output)
//     bus       requester bundle (slave modport)
//     ram_en    RAM ENA
//     ram_we    RAM WEA
//     ram_rst   RAM RSTA
//     ram_addr  RAM ADDRA
//     ram_din   RAM DIA
//     ram_dout  RAM DOA
// ---------------------------------------------------------------------------
module ramb4_s2_porta_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                           CLKA,
  input  logic                           RSTB,
  ramb4_s2_porta_arbiter_if.slave        bus,
  output logic                           ram_en,
  output logic                           ram_we,
  output logic                           ram_rst,
  output logic [10:0]                    ram_addr,
  output logic [1:0]                     ram_din,
  input  logic [1:0]                     ram_dout
);

  localparam int BEAT_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t             state_reg;
  logic [N_REQ-1:0]   gnt_reg;
  logic [N_REQ-1:0]   rvalid_reg;
  logic [BEAT_W-1:0]  beat_reg;

  logic               active;
  logic [N_REQ-1:0]   own_req;
  logic               owner_req;
  logic               owner_we;
  logic [N_REQ-1:0]   ack_next;
  logic               last_beat;

  logic [N_REQ-1:0]   win_onehot;
  logic               win_found;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
`ifdef RR_ARB_EN
  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [IDX_W:0] N_SUM = (IDX_W+1)'(N_REQ);

  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [IDX_W-1:0]   win_ofs;
  logic [IDX_W:0]     win_sum;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   rr_ptr_next;
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;

  // Rotate the request vector so that the pointer position becomes bit 0;
  // the first set bit of the rotated vector is the winner's offset.
  assign req_dbl = {bus.req, bus.req};
  assign req_rot = N_REQ'(req_dbl >> rr_ptr_reg);

  always_comb begin
    win_found = 1'b0;
    win_ofs   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!win_found && req_rot[j]) begin
        win_found = 1'b1;
        win_ofs   = IDX_W'(j);
      end
    end
    win_sum     = {1'b0, rr_ptr_reg} + {1'b0, win_ofs};
    win_idx     = (win_sum >= N_SUM) ? IDX_W'(win_sum - N_SUM) : IDX_W'(win_sum);
    win_onehot  = N_REQ'(1) << win_idx;
    rr_ptr_next = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
  end
`else
  always_comb begin
    win_found  = 1'b0;
    win_onehot = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!win_found && bus.req[j]) begin
        win_found     = 1'b1;
        win_onehot[j] = 1'b1;
      end
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Owner mux: gnt_reg is one-hot (or zero), so AND-OR selection suffices.
  // -------------------------------------------------------------------------
  logic [N_REQ-1:0][10:0] addr_term;
  logic [N_REQ-1:0][1:0]  din_term;
  logic [10:0]            addr_mux;
  logic [1:0]             din_mux;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mux
      assign addr_term[gi] = bus.addr[11*gi +: 11] & {11{gnt_reg[gi]}};
      assign din_term[gi]  = bus.wdata[2*gi +: 2]  & {2{gnt_reg[gi]}};
    end
  endgenerate

  always_comb begin
    addr_mux = '0;
    din_mux  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      addr_mux = addr_mux | addr_term[i];
      din_mux  = din_mux  | din_term[i];
    end
  end

  assign active    = (state_reg == ACTIVE);
  assign own_req   = gnt_reg & bus.req;
  assign owner_req = |own_req;
  assign owner_we  = |(own_req & bus.we);
  assign last_beat = (beat_reg == BEAT_W'(MAX_BURST - 1));

  // Reset suppresses the access so nothing is written and no read is
  // reported for the cycle in which RSTB is high.
  assign ack_next = (active && !RSTB) ? own_req : '0;

  // -------------------------------------------------------------------------
  // RAM pins. During reset the RAM is enabled with RSTA high so its output
  // register clears.
  // -------------------------------------------------------------------------
  assign ram_rst  = RSTB;
  assign ram_en   = RSTB | (active & owner_req);
  assign ram_we   = !RSTB & active & owner_we;
  assign ram_addr = active ? addr_mux : '0;
  assign ram_din  = active ? din_mux  : '0;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      rvalid_reg <= '0;
      beat_reg   <= '0;
`ifdef RR_ARB_EN
      rr_ptr_reg <= '0;
`endif
    end else begin
      // The RAM output register returns the word one cycle after a read.
      rvalid_reg <= ack_next & ~bus.we;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            gnt_reg   <= win_onehot;
            beat_reg  <= '0;
            state_reg <= ACTIVE;
`ifdef RR_ARB_EN
            rr_ptr_reg <= rr_ptr_next;
`endif
          end
        end
        ACTIVE: begin
          if (owner_req) begin
            beat_reg <= beat_reg + BEAT_W'(1);
          end
          // Dropped request and burst limit both end the grant; if they
          // coincide it is still a single transition.
          if (!owner_req || last_beat) begin
            gnt_reg   <= '0;
            state_reg <= IDLE;
          end
        end
        default: begin
          gnt_reg   <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt    = gnt_reg;
  assign bus.ack    = ack_next;
  assign bus.rvalid = rvalid_reg;
  assign bus.rdata  = ram_dout;
  assign bus.busy   = active;

endmodule
